// File: rtl/sccb_write_arbiter.sv
`timescale 1ns/1ps
// sccb_write_arbiter
// Shares the single SCCB register-write path between the ROM init sequencer
// (port 0) and the runtime tuning logic (port 1). Each grant becomes a two-byte
// store (address, value), a send strobe and a wait for the controller to finish.
// Optional build macro: SCCB_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog of
// TIMEOUT_CYCLES cycles; without it the arbiter waits indefinitely.
module sccb_write_arbiter #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int DATA_W         = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic [DATA_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] val0_i,
    input  logic [DATA_W-1:0] val1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              done0_o,
    output logic              done1_o,
    output logic              err0_o,
    output logic              err1_o,
    output logic [DATA_W-1:0] data_o,
    output logic              store_data_o,
    output logic              send_data_o,
    input  logic              device_rdy_i,
    input  logic              error_i,
    output logic              busy_o,
    output logic              last_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_ADDR,
        ST_LOAD_VAL,
        ST_STORE_END,
        ST_SEND,
        ST_SEND_END,
        ST_WAIT_DONE
    } state_t;

    state_t            state;
    logic              rr_ptr;     // port preferred when both request
    logic              port_sel;   // port owning the write in flight
    logic [DATA_W-1:0] val_q;      // captured register value
    logic              seen_busy;  // controller has dropped ready since SEND

    logic              win_vld;
    logic              win_port;
    logic [DATA_W-1:0] win_addr;
    logic [DATA_W-1:0] win_val;
    logic              pulse_q;
    logic              tmo_hit;

    // Arbitration: single requester wins outright, contention uses the pointer
    always_comb begin
        win_vld  = req0_i | req1_i;
        win_port = (req0_i & req1_i) ? rr_ptr : req1_i;
        win_addr = win_port ? addr1_i : addr0_i;
        win_val  = win_port ? val1_i  : val0_i;
        // The cycle that carries done/err is a settling cycle: no new grant,
        // so the finishing requester sees its result before re-arbitration.
        pulse_q  = done0_o | done1_o | err0_o | err1_o;
    end

`ifdef SCCB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Watchdog: cleared on the way into WAIT_DONE, counts while waiting there
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_SEND_END) begin
            tmo_cnt <= '0;
        end else if (state == ST_WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Fires on the edge that brings the count to TIMEOUT_CYCLES
    always_comb begin
        tmo_hit = (state == ST_WAIT_DONE) &&
                  (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    end
`else
    // No watchdog: WAIT_DONE only ends on error or completion
    always_comb begin
        tmo_hit = 1'b0;
    end
`endif

    // Write sequencer with registered command and status outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= 1'b0;
            port_sel     <= 1'b0;
            val_q        <= '0;
            seen_busy    <= 1'b0;
            gnt0_o       <= 1'b0;
            gnt1_o       <= 1'b0;
            done0_o      <= 1'b0;
            done1_o      <= 1'b0;
            err0_o       <= 1'b0;
            err1_o       <= 1'b0;
            data_o       <= '0;
            store_data_o <= 1'b0;
            send_data_o  <= 1'b0;
            busy_o       <= 1'b0;
            last_err_o   <= 1'b0;
        end else begin
            gnt0_o  <= 1'b0;
            gnt1_o  <= 1'b0;
            done0_o <= 1'b0;
            done1_o <= 1'b0;
            err0_o  <= 1'b0;
            err1_o  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (win_vld && !pulse_q) begin
                        port_sel     <= win_port;
                        rr_ptr       <= ~win_port;
                        val_q        <= win_val;
                        data_o       <= win_addr;
                        store_data_o <= 1'b1;
                        busy_o       <= 1'b1;
                        gnt0_o       <= ~win_port;
                        gnt1_o       <= win_port;
                        state        <= ST_LOAD_ADDR;
                    end
                end
                ST_LOAD_ADDR: begin
                    data_o <= val_q;
                    state  <= ST_LOAD_VAL;
                end
                ST_LOAD_VAL: begin
                    store_data_o <= 1'b0;
                    state        <= ST_STORE_END;
                end
                ST_STORE_END: begin
                    send_data_o <= 1'b1;
                    state       <= ST_SEND;
                end
                ST_SEND: begin
                    send_data_o <= 1'b0;
                    seen_busy   <= 1'b0;
                    state       <= ST_SEND_END;
                end
                ST_SEND_END: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (error_i) begin
                        err0_o     <= ~port_sel;
                        err1_o     <= port_sel;
                        last_err_o <= 1'b1;
                        busy_o     <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (device_rdy_i && seen_busy) begin
                        done0_o    <= ~port_sel;
                        done1_o    <= port_sel;
                        last_err_o <= 1'b0;
                        busy_o     <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (tmo_hit) begin
                        err0_o     <= ~port_sel;
                        err1_o     <= port_sel;
                        last_err_o <= 1'b1;
                        busy_o     <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (!device_rdy_i) begin
                        seen_busy <= 1'b1;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
